// File: rtl/tensor_dma_sink.sv
// Tensor-side DMA responder: four word banks (A, B, X results, W) with fill, drain and result-push paths.
// Optional TSINK_SHAPE_CHECK_EN: compare words moved against depth*width when a transfer completes.
module tensor_dma_sink #(
  parameter int DATAWIDTH  = 8,
  parameter int BANK_WORDS = 64,
  localparam int AW        = $clog2(BANK_WORDS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           set,
  input  logic [DATAWIDTH-1:0] depth_in,
  input  logic [DATAWIDTH-1:0] width_in,
  input  logic                 busy,
  input  logic                 tensor_wen,
  input  logic                 tensor_ren,
  input  logic                 finished_tr,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  output logic                 data_out_vld,
  input  logic                 res_wen,
  input  logic [DATAWIDTH-1:0] res_data,
  output logic [3:0]           bank_valid,
  output logic [AW:0]          x_count,
  output logic [DATAWIDTH-1:0] col_idx,
  output logic [DATAWIDTH-1:0] row_idx,
  output logic                 err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(BANK_WORDS);
  localparam logic [1:0]  SET_X    = 2'd2;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t                 state_q;
  logic [1:0]             set_q;
  logic [DATAWIDTH-1:0]   depth_q, width_q;
  logic [DATAWIDTH-1:0]   col_q, row_q, col_d, row_d;
  logic [AW:0]            wptr_q, x_count_q;
  logic [AW-1:0]          rptr_q, xwptr_q;
  logic                   busy_q;
  logic [DATAWIDTH-1:0]   mem_q [4][BANK_WORDS];

  logic fill_we, fill_ovf, pop_req, pop_ok, push_ok, push_drop, step, end_tr, shape_ok;

`ifdef TSINK_SHAPE_CHECK_EN
  logic [2*DATAWIDTH-1:0] moved_q, expect_words;
  assign expect_words = depth_q * width_q;
  assign shape_ok     = (moved_q == expect_words);
`else
  assign shape_ok     = 1'b1;
`endif

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(BANK_WORDS-1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    fill_we   = (state_q == FILL) && tensor_wen && (wptr_q != FULL_CNT);
    fill_ovf  = (state_q == FILL) && tensor_wen && (wptr_q == FULL_CNT);
    pop_req   = (state_q == DRAIN) && tensor_ren;
    pop_ok    = pop_req && (x_count_q != '0);
    // A full X can still accept a push when a pop frees a slot in the same cycle.
    push_ok   = res_wen && ((x_count_q != FULL_CNT) || pop_ok);
    push_drop = res_wen && !push_ok;
    step      = fill_we || pop_ok;
    end_tr    = finished_tr || (busy_q && !busy);
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if ((depth_q != '0) && (width_q != '0)) begin
      if (col_q == depth_q - 1'b1) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_we) mem_q[set_q][wptr_q[AW-1:0]] <= data_in;
    if (push_ok) mem_q[SET_X][xwptr_q]         <= res_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      set_q        <= '0;
      depth_q      <= '0;
      width_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      xwptr_q      <= '0;
      x_count_q    <= '0;
      busy_q       <= 1'b0;
      data_out     <= '0;
      data_out_vld <= 1'b0;
      bank_valid   <= '0;
      err          <= 1'b0;
`ifdef TSINK_SHAPE_CHECK_EN
      moved_q      <= '0;
`endif
    end else begin
      busy_q       <= busy;
      data_out_vld <= pop_req;
      if (pop_ok)       data_out <= mem_q[SET_X][rptr_q];
      else if (pop_req) data_out <= '0;
      if (push_ok) xwptr_q <= ptr_inc(xwptr_q);
      if (pop_ok)  rptr_q  <= ptr_inc(rptr_q);
      case ({push_ok, pop_ok})
        2'b10:   x_count_q <= x_count_q + 1'b1;
        2'b01:   x_count_q <= x_count_q - 1'b1;
        default: x_count_q <= x_count_q;
      endcase
      if (push_drop || fill_ovf || (pop_req && !pop_ok)) err <= 1'b1;
      if (step) begin
        col_q <= col_d;
        row_q <= row_d;
`ifdef TSINK_SHAPE_CHECK_EN
        moved_q <= moved_q + 1'b1;
`endif
      end
      case (state_q)
        IDLE: begin
          if (busy && !busy_q) begin
            set_q           <= set;
            depth_q         <= depth_in;
            width_q         <= width_in;
            col_q           <= '0;
            row_q           <= '0;
            wptr_q          <= '0;
            bank_valid[set] <= 1'b0;
            state_q         <= (set == SET_X) ? DRAIN : FILL;
`ifdef TSINK_SHAPE_CHECK_EN
            moved_q         <= '0;
`endif
          end
        end
        FILL: begin
          if (fill_we) wptr_q <= wptr_q + 1'b1;
          if (end_tr)  state_q <= DONE;
        end
        DRAIN: begin
          if (end_tr) state_q <= DONE;
        end
        default: begin
          if (set_q != SET_X) bank_valid[set_q] <= shape_ok;
          bank_valid[SET_X] <= (x_count_q != '0) && ((set_q != SET_X) || shape_ok);
          if (!shape_ok) err <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign x_count = x_count_q;
  assign col_idx = col_q;
  assign row_idx = row_q;

endmodule

// File: tb/tb_tensor_dma_sink.sv
// Directed bench for tensor_dma_sink: fill, drain, underflow, full-FIFO concurrency/wrap, shape and overflow.
module tb_tensor_dma_sink;

  localparam int DW = 8;
  localparam int BW = 64;
  localparam int AW = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    set;
  logic [DW-1:0] depth_in, width_in, data_in, res_data;
  logic          busy, tensor_wen, tensor_ren, finished_tr, res_wen;
  logic [DW-1:0] data_out, col_idx, row_idx;
  logic          data_out_vld, err;
  logic [3:0]    bank_valid;
  logic [AW:0]   x_count;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  tensor_dma_sink #(.DATAWIDTH(DW), .BANK_WORDS(BW)) dut (
    .clk(clk), .rst_n(rst_n), .set(set), .depth_in(depth_in), .width_in(width_in),
    .busy(busy), .tensor_wen(tensor_wen), .tensor_ren(tensor_ren), .finished_tr(finished_tr),
    .data_in(data_in), .data_out(data_out), .data_out_vld(data_out_vld),
    .res_wen(res_wen), .res_data(res_data), .bank_valid(bank_valid), .x_count(x_count),
    .col_idx(col_idx), .row_idx(row_idx), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic end_transfer();
    finished_tr = 1'b1;
    busy        = 1'b0;
    tick();
    finished_tr = 1'b0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; set = '0; depth_in = '0; width_in = '0; data_in = '0; res_data = '0;
    busy = 1'b0; tensor_wen = 1'b0; tensor_ren = 1'b0; finished_tr = 1'b0; res_wen = 1'b0;
    repeat (3) tick();
    chk("rst_data_out", data_out, 0);
    chk("rst_vld", data_out_vld, 0);
    chk("rst_bank_valid", bank_valid, 0);
    chk("rst_x_count", x_count, 0);
    chk("rst_col", col_idx, 0);
    chk("rst_row", row_idx, 0);
    chk("rst_err", err, 0);
    rst_n = 1'b1;
    tick();

    // fill A with a 3x2 tensor
    set = 2'd0; depth_in = 8'd3; width_in = 8'd2; busy = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk("fillA_col", col_idx, i % 3);
      chk("fillA_row", row_idx, i / 3);
      tensor_wen = 1'b1; data_in = 8'h10 + 8'(i);
      tick();
    end
    tensor_wen = 1'b0;
    end_transfer();
    chk("fillA_bank_valid", bank_valid, 4'b0001);
    chk("fillA_err", err, 0);

    // asynchronous reset in the middle of a fill of B
    set = 2'd1; depth_in = 8'd2; width_in = 8'd2; busy = 1'b1;
    tick();
    tensor_wen = 1'b1; data_in = 8'h55;
    tick();
    tick();
    tensor_wen = 1'b0;
    chk("midfill_row", row_idx, 1);
    rst_n = 1'b0;
    #2;
    chk("async_bank_valid", bank_valid, 0);
    chk("async_row", row_idx, 0);
    chk("async_col", col_idx, 0);
    chk("async_err", err, 0);
    busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tensor_wen = 1'b1;
    tick();
    tensor_wen = 1'b0;
    chk("idle_wen_ignored_col", col_idx, 0);

    // push four results, then drain them
    for (int i = 0; i < 4; i++) begin
      res_wen = 1'b1; res_data = 8'hA0 + 8'(i);
      tick();
    end
    res_wen = 1'b0;
    chk("push4_x_count", x_count, 4);
    set = 2'd2; depth_in = 8'd4; width_in = 8'd1; busy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tensor_ren = 1'b1;
      tick();
      chk("drain_data", data_out, 8'hA0 + 8'(i));
      chk("drain_vld", data_out_vld, 1);
      chk("drain_x_count", x_count, 3 - i);
    end
    tensor_ren = 1'b0;
    chk("drain_row", row_idx, 1);
    tick();
    chk("drain_vld_drop", data_out_vld, 0);
    chk("drain_data_hold", data_out, 8'hA3);
    end_transfer();
    chk("drain_bank_valid", bank_valid, 0);
    chk("drain_err", err, 0);

    // underflow
    busy = 1'b1;
    tick();
    tensor_ren = 1'b1;
    tick();
    tensor_ren = 1'b0;
    chk("uflow_data", data_out, 0);
    chk("uflow_vld", data_out_vld, 1);
    chk("uflow_err", err, 1);
    end_transfer();
    tick();
    chk("uflow_err_sticky", err, 1);

    // full X, simultaneous push and pop, pointer wrap, zero shape
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < BW; i++) begin
      res_wen = 1'b1; res_data = 8'h40 + 8'(i);
      tick();
    end
    res_wen = 1'b0;
    chk("full_x_count", x_count, BW);
    set = 2'd2; depth_in = 8'd0; width_in = 8'd0; busy = 1'b1;
    tick();
    res_wen = 1'b1; res_data = 8'hEE; tensor_ren = 1'b1;
    tick();
    res_wen = 1'b0;
    chk("concur_data", data_out, 8'h40);
    chk("concur_x_count", x_count, BW);
    chk("concur_err", err, 0);
    for (int i = 1; i < BW; i++) begin
      tick();
      chk("wrap_drain_data", data_out, 8'h40 + 8'(i));
    end
    chk("wrap_x_count_last", x_count, 1);
    tick();
    tensor_ren = 1'b0;
    chk("wrap_data", data_out, 8'hEE);
    chk("wrap_x_count", x_count, 0);
    chk("zero_shape_col", col_idx, 0);
    chk("zero_shape_row", row_idx, 0);
    chk("wrap_err", err, 0);
    end_transfer();

    // short transfer into W
    set = 2'd3; depth_in = 8'd2; width_in = 8'd2; busy = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tensor_wen = 1'b1; data_in = 8'h30 + 8'(i);
      tick();
    end
    tensor_wen = 1'b0;
    end_transfer();
`ifdef TSINK_SHAPE_CHECK_EN
    chk("shape_bank_valid_w", bank_valid[3], 0);
    chk("shape_err", err, 1);
`else
    chk("shape_bank_valid_w", bank_valid[3], 1);
    chk("shape_err", err, 0);
`endif

    // fill overflow on B
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    set = 2'd1; depth_in = 8'd8; width_in = 8'd8; busy = 1'b1;
    tick();
    for (int i = 0; i < BW; i++) begin
      tensor_wen = 1'b1; data_in = 8'(i);
      tick();
    end
    chk("ovf_err_before", err, 0);
    tick();
    tensor_wen = 1'b0;
    chk("ovf_err_after", err, 1);
    end_transfer();
    chk("ovf_bank_valid", bank_valid, 4'b0010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
